// File: rtl/seg_pkg.sv
// Shared constants for the BCD up/down counter and its 7-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Non-decimal codes cannot occur in a legal count; show them blank.
    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: scan prescaler, digit index, digit mux,
// decoder and registered anode/cathode/decimal-point outputs.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DIGITS*BCD_W-1:0]     i_cnt,
    input  logic                        i_down,
    output logic                        o_dp_n,
    output logic [6:0]                  o_seg_n,
    output logic [MAX_DIGITS-1:0]       o_an_n
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(MAX_DIGITS);

    logic [SCAN_W-1:0]             r_scan;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_dp_n;
    logic [6:0]                    r_seg_n;
    logic [MAX_DIGITS-1:0]         r_an_n;

    logic [MAX_DIGITS*BCD_W-1:0]   w_cnt_pad;
    logic [BCD_W-1:0]              w_digit;
    logic                          w_blank;

    // Widen the count to the full digit range so the mux indexes stay constant.
    always_comb begin
        w_cnt_pad = '0;
        w_cnt_pad[DIGITS*BCD_W-1:0] = i_cnt;
    end

    // Select the BCD digit addressed by the current scan index.
    always_comb begin
        w_digit = '0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit = w_cnt_pad[k*BCD_W +: BCD_W];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a non-zero index whose digit and every higher digit are zero.
    always_comb begin
        w_blank = (r_idx != '0);
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if ((IDX_W'(k) >= r_idx) && (w_cnt_pad[k*BCD_W +: BCD_W] != '0)) begin
                w_blank = 1'b0;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Advance the scan slot and register the drive for the current digit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan  <= '0;
            r_idx   <= '0;
            r_dp_n  <= 1'b1;
            r_seg_n <= SEG_BLANK;
            r_an_n  <= '1;
        end else begin
            if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_scan <= r_scan + SCAN_W'(1);
            end
            r_an_n  <= ~(MAX_DIGITS'(1) << r_idx);
            r_seg_n <= w_blank ? SEG_BLANK : seg_decode(w_digit);
            r_dp_n  <= ~((r_idx == '0) && i_down);
        end
    end

    assign o_dp_n  = r_dp_n;
    assign o_seg_n = r_seg_n;
    assign o_an_n  = r_an_n;

endmodule

// File: rtl/updown_seg_counter_n.sv
// DIGITS-digit BCD up/down counter with programmable count rate and a
// multiplexed active-low 7-segment display.
// DIGITS: 1..8, SCAN_DIV: >= 2 clocks per display slot.
// Optional feature macro: LEADING_ZERO_BLANK_EN (handled in seg_scan).
module updown_seg_counter_n
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clkt,
    input  logic                  rstt,
    input  logic [4:0]            SW1,
    input  logic                  udt,
    input  logic                  ent,
    output logic                  seg,
    output logic [6:0]            Cnode1,
    output logic [MAX_DIGITS-1:0] AN1,
    output logic                  wrapt
);

    localparam int CNT_W = DIGITS * BCD_W;

    logic [31:0]      r_presc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;

    logic [31:0]      w_mask;
    logic             w_tick;
    dir_e             w_dir;
    logic [CNT_W-1:0] w_next;
    logic [BCD_W-1:0] w_dig;
    logic             w_carry;

    // SW1 picks how many low prescaler bits must all be ones for a tick.
    assign w_mask = (32'd1 << SW1) - 32'd1;
    assign w_tick = ((r_presc & w_mask) == w_mask);
    assign w_dir  = dir_e'(udt);

    // Ripple a carry (up) or borrow (down) through the BCD digits; a carry
    // out of the top digit is exactly the wrap condition.
    always_comb begin
        w_next  = r_cnt;
        w_dig   = '0;
        w_carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            w_dig = r_cnt[d*BCD_W +: BCD_W];
            if (w_carry) begin
                if (w_dir == DIR_UP) begin
                    if (w_dig == 4'd9) begin
                        w_next[d*BCD_W +: BCD_W] = 4'd0;
                    end else begin
                        w_next[d*BCD_W +: BCD_W] = w_dig + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_next[d*BCD_W +: BCD_W] = 4'd9;
                    end else begin
                        w_next[d*BCD_W +: BCD_W] = w_dig - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end
        end
    end

    // Free-running prescaler and the counter with its one-cycle wrap pulse.
    always_ff @(posedge clkt) begin
        if (rstt) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_presc <= r_presc + 32'd1;
            r_wrap  <= 1'b0;
            if (w_tick && ent) begin
                r_cnt  <= w_next;
                r_wrap <= w_carry;
            end
        end
    end

    assign wrapt = r_wrap;

    seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .i_clk   (clkt),
        .i_rst   (rstt),
        .i_cnt   (r_cnt),
        .i_down  (w_dir == DIR_DOWN),
        .o_dp_n  (seg),
        .o_seg_n (Cnode1),
        .o_an_n  (AN1)
    );

endmodule
